// File: rtl/mult4_serial_sched.sv
// mult4_serial_sched
// 4x4 unsigned multiplier built around one shared, externally attached 2x2
// multiplier. The four half-operand pairs are issued one after another
// (ll, lh, hl, hh). Each partial product is shifted and added into an 8-bit
// accumulator. Operands arrive over valid/ready and the product leaves over
// valid/ready.
//
// Step schedule (one step = SUB_LAT+1 cycles):
//   step 0 : A[1:0] x B[1:0]  << 0
//   step 1 : A[1:0] x B[3:2]  << 2
//   step 2 : A[3:2] x B[1:0]  << 2
//   step 3 : A[3:2] x B[3:2]  << 4
// The first product is visible exactly 4*(SUB_LAT+1) edges after the accept
// edge.

module mult4_serial_sched #(
    // Pipeline latency of the attached 2x2 unit in cycles. Legal range is 0..3.
    parameter int SUB_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    // operand side
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] A,
    input  logic [3:0] B,
    // product side
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] P,
    // shared 2x2 unit
    output logic [1:0] sub_a,
    output logic [1:0] sub_b,
    input  logic [3:0] sub_p,
    // status / debug
    output logic       busy,
    output logic [1:0] step
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Value of the wait counter on the last cycle of a step. On this cycle,
    // sub_p carries the product of the pair that was issued when the step began.
    localparam logic [1:0] LAST_WAIT = 2'(SUB_LAT);

    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [7:0] r_acc;
    logic [7:0] r_p;
    logic [1:0] r_step;
    logic [1:0] r_wait;
    logic [1:0] r_sub_a;
    logic [1:0] r_sub_b;

    logic       w_accept;
    logic       w_release;
    logic       w_step_last;
    logic       w_final_step;
    logic [1:0] w_step_inc;
    logic [1:0] w_next_a;
    logic [1:0] w_next_b;
    logic [7:0] w_partial;
    logic [7:0] w_acc_sum;

    // ------------------------------------------------------------------
    // Handshake and step qualifiers
    // ------------------------------------------------------------------
    assign w_accept     = (r_state == ST_IDLE) && in_valid;
    assign w_release    = (r_state == ST_DONE) && out_ready;
    assign w_step_last  = (r_state == ST_STEP) && (r_wait == LAST_WAIT);
    assign w_final_step = w_step_last && (r_step == 2'd3);

    // Operand halves for the step that follows the current one.
    // Bit 1 of the step index selects the A half.
    // Bit 0 of the step index selects the B half.
    assign w_step_inc = r_step + 2'd1;
    assign w_next_a   = w_step_inc[1] ? r_a[3:2] : r_a[1:0];
    assign w_next_b   = w_step_inc[0] ? r_b[3:2] : r_b[1:0];

    // Align the current partial product to its weight in the full product.
    always_comb begin
        // NOTE: every always_comb output gets a default before the case, so
        // no path can leave it unassigned and infer a latch.
        w_partial = 8'd0;
        case (r_step)
            2'd0:    w_partial = {4'b0000, sub_p};
            2'd1,
            2'd2:    w_partial = {2'b00, sub_p, 2'b00};
            default: w_partial = {sub_p, 4'b0000};
        endcase
    end

    // 15*15 = 225 fits in 8 bits, so the accumulator cannot overflow.
    assign w_acc_sum = r_acc + w_partial;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // Hold the control state. An asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated only with non-blocking assignments,
        // so every register samples values from before the edge.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> STEP -> DONE -> IDLE with no bypass paths.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)     w_state_next = ST_STEP;
            ST_STEP: if (w_final_step) w_state_next = ST_DONE;
            ST_DONE: if (w_release)    w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Latch operands, drive the shared unit, accumulate the partials, and capture the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_acc   <= 8'd0;
            r_p     <= 8'd0;
            r_step  <= 2'd0;
            r_wait  <= 2'd0;
            r_sub_a <= 2'd0;
            r_sub_b <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_acc   <= 8'd0;
                        r_step  <= 2'd0;
                        r_wait  <= 2'd0;
                        // The first pair comes straight from the ports, so
                        // the shared unit starts working on the accept edge.
                        r_sub_a <= A[1:0];
                        r_sub_b <= B[1:0];
                    end
                end

                ST_STEP: begin
                    if (w_step_last) begin
                        r_wait <= 2'd0;
                        r_acc  <= w_acc_sum;
                        if (r_step == 2'd3) begin
                            // Last partial: publish the product and park
                            // the shared unit on zero while the block waits.
                            r_p     <= w_acc_sum;
                            r_step  <= 2'd0;
                            r_sub_a <= 2'd0;
                            r_sub_b <= 2'd0;
                        end else begin
                            r_step  <= w_step_inc;
                            r_sub_a <= w_next_a;
                            r_sub_b <= w_next_b;
                        end
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end

                default: begin
                    // DONE (and any unused encoding): hold everything.
                    // P stays stable until the consumer takes it.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_STEP) || (r_state == ST_DONE);
    assign P         = r_p;
    assign sub_a     = r_sub_a;
    assign sub_b     = r_sub_b;
    assign step      = r_step;

endmodule

// File: tb/tb_mult4_serial_sched.sv
// tb_mult4_serial_sched
// Drives two instances of mult4_serial_sched. Index 0 uses SUB_LAT=0 and
// index 1 uses SUB_LAT=2. Each instance has its own model of the 2x2 unit,
// which returns the exact product delayed by SUB_LAT cycles. The expected
// pair sequence, step timing, latency and product come from plain arithmetic
// on the operands.

module tb_mult4_serial_sched;

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       busy;
        logic [7:0] p;
        logic [1:0] sub_a;
        logic [1:0] sub_b;
        logic [1:0] step;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid  [2];
    logic       out_ready [2];
    logic [3:0] a_in      [2];
    logic [3:0] b_in      [2];

    logic       ir_0, ov_0, bz_0, ir_2, ov_2, bz_2;
    logic [7:0] p_0, p_2;
    logic [1:0] sa_0, sb_0, st_0, sa_2, sb_2, st_2;
    logic [3:0] sp_0, sp_2;
    logic [3:0] pipe_q1, pipe_q2;

    obs_t       o_0, o_2;

    int         n_vec  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    mult4_serial_sched #(.SUB_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(ir_0), .A(a_in[0]), .B(b_in[0]),
        .out_valid(ov_0), .out_ready(out_ready[0]), .P(p_0),
        .sub_a(sa_0), .sub_b(sb_0), .sub_p(sp_0),
        .busy(bz_0), .step(st_0)
    );

    mult4_serial_sched #(.SUB_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(ir_2), .A(a_in[1]), .B(b_in[1]),
        .out_valid(ov_2), .out_ready(out_ready[1]), .P(p_2),
        .sub_a(sa_2), .sub_b(sb_2), .sub_p(sp_2),
        .busy(bz_2), .step(st_2)
    );

    // 2x2 unit for instance 0: combinational exact product.
    assign sp_0 = {2'b00, sa_0} * {2'b00, sb_0};

    // 2x2 unit for instance 1: exact product seen two cycles later.
    always_ff @(posedge clk) begin
        pipe_q1 <= {2'b00, sa_2} * {2'b00, sb_2};
        pipe_q2 <= pipe_q1;
    end
    assign sp_2 = pipe_q2;

    assign o_0 = {ir_0, ov_0, bz_0, p_0, sa_0, sb_0, st_0};
    assign o_2 = {ir_2, ov_2, bz_2, p_2, sa_2, sb_2, st_2};

    function automatic obs_t ob(input int u);
        return (u == 0) ? o_0 : o_2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks the quiet state that IDLE and reset have in common.
    task automatic check_idle(input int u, input string tag);
        obs_t o;
        o = ob(u);
        check({tag, "_in_ready"},  32'(o.in_ready),  1);
        check({tag, "_out_valid"}, 32'(o.out_valid), 0);
        check({tag, "_busy"},      32'(o.busy),      0);
        check({tag, "_sub_a"},     32'(o.sub_a),     0);
        check({tag, "_sub_b"},     32'(o.sub_b),     0);
        check({tag, "_step"},      32'(o.step),      0);
    endtask

    task automatic check_reset(input int u, input string tag);
        check_idle(u, tag);
        check({tag, "_p"}, 32'(ob(u).p), 0);
    endtask

    // Runs one multiply. Inputs are scrambled while the instance is busy,
    // and out_ready is held low for 'hold' cycles once the product is valid.
    task automatic run_op(input int u, input int a, input int b, input int hold);
        int   cyc_per_step;
        int   s;
        int   exp_a;
        int   exp_b;
        int   exp_p;
        obs_t o;
        cyc_per_step = (u == 0) ? 1 : 3;
        exp_p        = a * b;

        check("pre_accept_ready", 32'(ob(u).in_ready), 1);
        a_in[u]     = 4'(a);
        b_in[u]     = 4'(b);
        in_valid[u] = 1'b1;
        tick();

        for (int c = 0; c < 4 * cyc_per_step; c++) begin
            in_valid[u]  = 1'($urandom);
            a_in[u]      = 4'($urandom);
            b_in[u]      = 4'($urandom);
            out_ready[u] = 1'($urandom);
            s     = c / cyc_per_step;
            exp_a = (s < 2)      ? (a % 4) : (a / 4);
            exp_b = (s % 2 == 0) ? (b % 4) : (b / 4);
            o = ob(u);
            check("step_busy",      32'(o.busy),      1);
            check("step_in_ready",  32'(o.in_ready),  0);
            check("step_out_valid", 32'(o.out_valid), 0);
            check("step_index",     32'(o.step),      32'(s));
            check("step_sub_a",     32'(o.sub_a),     32'(exp_a));
            check("step_sub_b",     32'(o.sub_b),     32'(exp_b));
            tick();
        end

        o = ob(u);
        check("done_out_valid", 32'(o.out_valid), 1);
        check("done_product",   32'(o.p),         32'(exp_p));
        check("done_in_ready",  32'(o.in_ready),  0);
        check("done_busy",      32'(o.busy),      1);
        check("done_step",      32'(o.step),      0);
        check("done_sub_a",     32'(o.sub_a),     0);
        check("done_sub_b",     32'(o.sub_b),     0);

        out_ready[u] = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid[u] = 1'($urandom);
            a_in[u]     = 4'($urandom);
            b_in[u]     = 4'($urandom);
            tick();
            o = ob(u);
            check("hold_out_valid", 32'(o.out_valid), 1);
            check("hold_product",   32'(o.p),         32'(exp_p));
            check("hold_in_ready",  32'(o.in_ready),  0);
        end

        out_ready[u] = 1'b1;
        tick();
        in_valid[u] = 1'b0;
        check_idle(u, "release");
    endtask

    initial begin
        int q[$];
        int got;
        int last_acc;
        int exp_p;
        bit acc_now;

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b0;
            a_in[u]      = 4'd0;
            b_in[u]      = 4'd0;
        end
        #2;
        check_reset(0, "por0");
        check_reset(1, "por2");
        #10;
        rst_n = 1'b1;
        tick();
        check_reset(0, "idle0");

        // Operands 0xB and 0x6 issue the pairs (3,2), (3,1), (2,2), (2,1) and give P=66.
        run_op(0, 11, 6, 0);

        // Corner operands, then every operand pair.
        run_op(0, 15, 15, 0);
        run_op(0, 0, 9, 0);
        for (int i = 0; i < 256; i++) begin
            run_op(0, i / 16, i % 16, 0);
        end

        // Backpressure for 10 cycles, with in_valid toggling.
        run_op(0, 10, 13, 10);

        // Reset during step 2 discards the operation.
        a_in[0]     = 4'd5;
        b_in[0]     = 4'd14;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        check("mid_step_index", 32'(ob(0).step), 2);
        rst_n = 1'b0;
        #1;
        check_reset(0, "midrst0");
        check_reset(1, "midrst2");
        #2;
        rst_n = 1'b1;
        tick();
        check_idle(0, "post_rst");
        run_op(0, 7, 9, 0);

        // SUB_LAT=2: each pair is held for 3 cycles, and out_valid rises 12 edges after accept.
        run_op(1, 13, 11, 0);
        for (int i = 0; i < 8; i++) begin
            run_op(1, int'($urandom_range(15)), int'($urandom_range(15)),
                   int'($urandom_range(3)));
        end

        // in_valid and out_ready held high: one accept every 6 cycles, with products in order.
        got          = 0;
        last_acc     = -1;
        out_ready[0] = 1'b1;
        a_in[0]      = 4'($urandom);
        b_in[0]      = 4'($urandom);
        in_valid[0]  = 1'b1;
        for (int t = 0; t < 80 && got < 5; t++) begin
            acc_now = ob(0).in_ready;
            if (acc_now) begin
                q.push_back(int'(a_in[0]) * int'(b_in[0]));
                if (last_acc >= 0) check("cont_issue_period", 32'(t - last_acc), 6);
                last_acc = t;
            end
            if (ob(0).out_valid) begin
                exp_p = (q.size() > 0) ? q[0] : -1;
                if (q.size() > 0) void'(q.pop_front());
                check("cont_product", 32'(ob(0).p), 32'(exp_p));
                got++;
                if (got == 5) in_valid[0] = 1'b0;
            end
            tick();
            if (acc_now) begin
                a_in[0] = 4'($urandom);
                b_in[0] = 4'($urandom);
            end
        end
        check("cont_products_seen", 32'(got), 5);
        check("cont_queue_drained", 32'(q.size()), 0);
        check_idle(0, "cont_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
